// File: rtl/hpu_aer_pkg.sv
// Shared types and sizing for the HPU AER receive path.
package hpu_aer_pkg;

    localparam int unsigned AER_DATA_W      = 24;
    localparam int unsigned AER_CNT_W       = 32;
    localparam int unsigned AER_SETTLE_W    = 2;
    localparam int unsigned AER_TIMEOUT_CYC = 4096;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned AER_TO_W = cnt_w(AER_TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPT,
        ACK_WAIT,
        WAIT_REL
    } aer_rx_state_e;

endpackage

// File: rtl/aer_rx_hs_if.sv
// AER bundled-data port plus the event stream towards the RX FIFO writer.
interface aer_rx_hs_if
    import hpu_aer_pkg::*;
#(
    parameter int unsigned DATA_W = AER_DATA_W
) ();

    logic                 aer_req_n;
    logic [DATA_W-1:0]    aer_data;
    logic                 aer_ack_n;
    logic [DATA_W-1:0]    ev_data;
    logic                 ev_valid;
    logic                 ev_ready;
    logic                 err_timeout;
    logic [AER_CNT_W-1:0] ev_count;

    modport master (
        output aer_req_n, aer_data, ev_ready,
        input  aer_ack_n, ev_data, ev_valid, err_timeout, ev_count
    );

    modport slave (
        input  aer_req_n, aer_data, ev_ready,
        output aer_ack_n, ev_data, ev_valid, err_timeout, ev_count
    );

endinterface

// File: rtl/aer_sync.sv
// Flop-chain synchroniser with a configurable reset value.
module aer_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk) begin
        if (rst) ff_q <= {STAGES{RST_VAL}};
        else     ff_q <= {ff_q[STAGES-2:0], d};
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/aer_rx_hs.sv
// 4-phase bundled-data AER receiver: synchronises req, samples the bus after
// a settle delay, acknowledges, and hands each event to a one-entry stream register.
module aer_rx_hs
    import hpu_aer_pkg::*;
#(
    parameter int unsigned DATA_W      = AER_DATA_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE_CYC  = 1,
    parameter int unsigned TIMEOUT_CYC = AER_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    aer_rx_hs_if.slave bus
);

    localparam int unsigned TO_W = cnt_w(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    aer_rx_state_e            state_q, state_d;
    logic                     req_s, req_live;
    logic                     slot_free, xfer;
    logic [AER_SETTLE_W-1:0]  settle_q, settle_d;
    logic [TO_W-1:0]          to_q, to_d;
    logic                     ack_n_q, ack_n_d;
    logic                     ev_valid_q, ev_valid_d;
    logic [DATA_W-1:0]        ev_data_q, ev_data_d;
    logic                     err_q, err_d;
    logic [AER_CNT_W-1:0]     ev_count_q, ev_count_d;

    aer_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.aer_req_n),
        .q   (req_s)
    );

    // Goes high once the req chain holds pin samples rather than reset values,
    // so a request held low across reset is not mistaken for a release.
    aer_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_live (
        .clk (clk),
        .rst (rst),
        .d   (1'b1),
        .q   (req_live)
    );

    assign slot_free = !ev_valid_q || bus.ev_ready;
    assign xfer      = ev_valid_q && bus.ev_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT_REL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!req_s) state_d = SETTLE;
            SETTLE: begin
                if (req_s)                 state_d = IDLE;
                else if (settle_q == '0)   state_d = CAPT;
            end
            CAPT:     if (slot_free) state_d = ACK_WAIT;
            ACK_WAIT: begin
                if (req_s)                 state_d = IDLE;
                else if (to_q == TO_LAST)  state_d = WAIT_REL;
            end
            WAIT_REL: if (req_s && req_live) state_d = IDLE;
            default:  state_d = WAIT_REL;
        endcase
    end

    // Next values for the registered outputs and counters.
    always_comb begin
        settle_d   = settle_q;
        to_d       = to_q;
        ack_n_d    = ack_n_q;
        ev_valid_d = ev_valid_q && !bus.ev_ready;
        ev_data_d  = ev_data_q;
        err_d      = 1'b0;
        ev_count_d = ev_count_q + AER_CNT_W'(xfer);
        case (state_q)
            IDLE:   settle_d = AER_SETTLE_W'(SETTLE_CYC);
            SETTLE: if (settle_q != '0) settle_d = settle_q - 1'b1;
            CAPT: begin
                if (slot_free) begin
                    ev_data_d  = bus.aer_data;
                    ev_valid_d = 1'b1;
                    ack_n_d    = 1'b0;
                    to_d       = '0;
                end
            end
            ACK_WAIT: begin
                if (req_s) begin
                    ack_n_d = 1'b1;
                end else if (to_q == TO_LAST) begin
                    ack_n_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            WAIT_REL: ack_n_d = 1'b1;
            default:  ack_n_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q   <= '0;
            to_q       <= '0;
            ack_n_q    <= 1'b1;
            ev_valid_q <= 1'b0;
            ev_data_q  <= '0;
            err_q      <= 1'b0;
            ev_count_q <= '0;
        end else begin
            settle_q   <= settle_d;
            to_q       <= to_d;
            ack_n_q    <= ack_n_d;
            ev_valid_q <= ev_valid_d;
            ev_data_q  <= ev_data_d;
            err_q      <= err_d;
            ev_count_q <= ev_count_d;
        end
    end

    assign bus.aer_ack_n   = ack_n_q;
    assign bus.ev_valid    = ev_valid_q;
    assign bus.ev_data     = ev_data_q;
    assign bus.err_timeout = err_q;
    assign bus.ev_count    = ev_count_q;

endmodule

// File: tb/tb_aer_rx_hs.sv
// Directed and randomised-order bench for aer_rx_hs (timeout shortened to 16 cycles).
module tb_aer_rx_hs;
    import hpu_aer_pkg::*;

    localparam int unsigned DATA_W      = AER_DATA_W;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int          N_EV        = 1000;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [DATA_W-1:0] exp_q[$];

    aer_rx_hs_if #(.DATA_W(DATA_W)) bus ();

    aer_rx_hs #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .SETTLE_CYC  (1),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ack(input logic lvl, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (bus.aer_ack_n !== lvl && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (bus.aer_ack_n !== lvl) check(tag, 32'(bus.aer_ack_n), 32'(lvl));
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input int dly, input int max_wait);
        repeat (dly) @(negedge clk);
        bus.aer_data  = d;
        bus.aer_req_n = 1'b0;
        wait_ack(1'b0, max_wait, "ack_fall_wait");
        bus.aer_req_n = 1'b1;
        wait_ack(1'b1, 20, "ack_rise_wait");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int got, cyc;
        logic stall;
        logic [DATA_W-1:0] hold_d;
        logic [31:0] exp_d;

        rst = 1'b1;
        bus.aer_req_n = 1'b1;
        bus.aer_data  = '0;
        bus.ev_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack_n", 32'(bus.aer_ack_n), 32'd1);
        check("rst_valid", 32'(bus.ev_valid), 32'd0);
        check("rst_data",  32'(bus.ev_data), 32'd0);
        check("rst_err",   32'(bus.err_timeout), 32'd0);
        check("rst_count", bus.ev_count, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single event, cycle-exact latency
        bus.ev_ready  = 1'b1;
        bus.aer_data  = 24'hABCDEF;
        bus.aer_req_n = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_ack_early", 32'(bus.aer_ack_n), 32'd1);
        @(negedge clk);
        check("t1_ack_low", 32'(bus.aer_ack_n), 32'd0);
        check("t1_valid",   32'(bus.ev_valid), 32'd1);
        check("t1_data",    32'(bus.ev_data), 32'h00ABCDEF);
        bus.aer_req_n = 1'b1;
        @(negedge clk);
        check("t1_valid_drop", 32'(bus.ev_valid), 32'd0);
        check("t1_count",      bus.ev_count, 32'd1);
        @(negedge clk);
        check("t1_ack_hold", 32'(bus.aer_ack_n), 32'd0);
        @(negedge clk);
        check("t1_ack_rel", 32'(bus.aer_ack_n), 32'd1);

        // 2: backpressure
        bus.ev_ready = 1'b0;
        send(24'h000001, 2, 40);
        check("t2_v1",     32'(bus.ev_valid), 32'd1);
        check("t2_d1",     32'(bus.ev_data), 32'h1);
        check("t2_cnt1",   bus.ev_count, 32'd1);
        bus.aer_data  = 24'h000002;
        bus.aer_req_n = 1'b0;
        repeat (10) @(negedge clk);
        check("t2_ack_withheld", 32'(bus.aer_ack_n), 32'd1);
        check("t2_d1_held",      32'(bus.ev_data), 32'h1);
        bus.ev_ready = 1'b1;
        @(negedge clk);
        check("t2_d2",     32'(bus.ev_data), 32'h2);
        check("t2_v2",     32'(bus.ev_valid), 32'd1);
        check("t2_ack2",   32'(bus.aer_ack_n), 32'd0);
        check("t2_cnt2",   bus.ev_count, 32'd2);
        @(negedge clk);
        check("t2_v_drop", 32'(bus.ev_valid), 32'd0);
        check("t2_cnt3",   bus.ev_count, 32'd3);
        bus.aer_req_n = 1'b1;
        wait_ack(1'b1, 20, "t2_ack_rise_wait");

        // 3: timeout with req held low
        bus.aer_data  = 24'h000033;
        bus.aer_req_n = 1'b0;
        wait_ack(1'b0, 20, "t3_ack_fall_wait");
        check("t3_data", 32'(bus.ev_data), 32'h33);
        repeat (15) @(negedge clk);
        check("t3_ack_last", 32'(bus.aer_ack_n), 32'd0);
        check("t3_err_early", 32'(bus.err_timeout), 32'd0);
        @(negedge clk);
        check("t3_ack_to", 32'(bus.aer_ack_n), 32'd1);
        check("t3_err",    32'(bus.err_timeout), 32'd1);
        @(negedge clk);
        check("t3_err_pulse", 32'(bus.err_timeout), 32'd0);
        repeat (10) @(negedge clk);
        check("t3_ack_stays", 32'(bus.aer_ack_n), 32'd1);
        check("t3_no_dup",    bus.ev_count, 32'd4);
        bus.aer_req_n = 1'b1;
        repeat (4) @(negedge clk);
        send(24'h000044, 0, 20);
        check("t3_next_data", 32'(bus.ev_data), 32'h44);
        check("t3_next_cnt",  bus.ev_count, 32'd5);

        // 4: reset mid-handshake with req held low
        bus.ev_ready  = 1'b0;
        bus.aer_data  = 24'h000055;
        bus.aer_req_n = 1'b0;
        wait_ack(1'b0, 20, "t4_ack_fall_wait");
        rst = 1'b1;
        @(negedge clk);
        check("t4_ack",   32'(bus.aer_ack_n), 32'd1);
        check("t4_valid", 32'(bus.ev_valid), 32'd0);
        check("t4_data",  32'(bus.ev_data), 32'd0);
        check("t4_count", bus.ev_count, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("t4_no_capture", 32'(bus.aer_ack_n), 32'd1);
        check("t4_no_valid",   32'(bus.ev_valid), 32'd0);
        bus.aer_req_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.ev_ready = 1'b1;
        send(24'h000066, 0, 20);
        check("t4_new_data", 32'(bus.ev_data), 32'h66);
        check("t4_new_cnt",  bus.ev_count, 32'd1);

        // 5: random back-to-back traffic with random backpressure
        got   = 0;
        cyc   = 0;
        stall = 1'b0;
        hold_d = '0;
        fork
            begin
                for (int i = 0; i < N_EV; i++) begin
                    logic [DATA_W-1:0] d;
                    if (n_err > 50) break;
                    d = DATA_W'($urandom);
                    exp_q.push_back(d);
                    send(d, int'($urandom_range(0, 5)), 200);
                end
            end
            begin
                while (got < N_EV && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    if (stall) begin
                        check("t5_hold_valid", 32'(bus.ev_valid), 32'd1);
                        check("t5_hold_data",  32'(bus.ev_data), 32'(hold_d));
                    end
                    bus.ev_ready = 1'($urandom_range(0, 1));
                    if (bus.ev_valid && bus.ev_ready) begin
                        exp_d = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 'x;
                        check("t5_order", 32'(bus.ev_data), exp_d);
                        got++;
                    end
                    stall  = bus.ev_valid && !bus.ev_ready;
                    hold_d = bus.ev_data;
                end
            end
        join
        check("t5_received", 32'(got), 32'(N_EV));
        bus.ev_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_count",   bus.ev_count, 32'(N_EV + 1));
        check("t5_leftover", 32'(exp_q.size()), 32'd0);
        check("t5_valid",   32'(bus.ev_valid), 32'd0);

        // 6: counter wrap
        force dut.ev_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.ev_count_q;
        check("t6_preset", bus.ev_count, 32'hFFFF_FFFF);
        send(24'h000077, 1, 20);
        check("t6_wrap", bus.ev_count, 32'd0);
        check("t6_data", 32'(bus.ev_data), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
